int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Priority interrupt controller that sequences interrupt entry and exit for the program counter.
- Latches edge-triggered requests from up to NUM_IRQ sources and applies a mask and a global enable.
- Picks the highest-priority pending source and drives int_occurred/int_vec to the PC, holding the request until the pipeline accepts it.
- Blocks further entries until the ISR completes with RTI, since nested ISRs are not supported; software configures it through a small register port.

Parameters:
NUM_IRQ, 8, number of interrupt sources (1..16)
VEC_BASE, 16'h0F00, vector address of source 0
VEC_STRIDE, 4, address spacing between consecutive source vectors

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
irq  input  NUM_IRQ  interrupt request lines, rising edge sets pending
stall_IM_ID  input  1  pipeline stall; interrupt accepted only when low
rti_ID_EX  input  1  RTI in EX stage, ends the ISR
cfg_we  input  1  register write strobe
cfg_addr  input  2  register select
cfg_wdata  input  16  write data
cfg_rdata  output  16  read data (combinational on cfg_addr)
int_occurred  output  1  interrupt request to PC
int_vec  output  16  vector address for int_occurred
in_isr  output  1  ISR in progress
active_id  output  4  source id being serviced

Behaviour:
- Reset: int_occurred=0, in_isr=0, active_id=0, int_vec=VEC_BASE, MASK=0, PENDING=0, GIE=0, edge-detect history=0, state=IDLE.
- Register map:
  - 0 MASK: R/W; bit i enables source i.
  - 1 PENDING: read; write-1-to-clear.
  - 2 CTRL: bit0 = GIE, R/W.
  - 3 STATUS: read-only, {11'b0, in_isr, active_id}.
  - Bits at or above NUM_IRQ read 0 and ignore writes.
- Pending set: PENDING[i] sets on the cycle after irq[i] goes 0->1 (registered edge detect). A set and a clear in the same cycle: set wins.
- Eligible = PENDING & MASK & {GIE}. Winner = lowest-index eligible bit.
- int_vec = VEC_BASE + winner*VEC_STRIDE, truncated to 16 bits, registered with int_occurred.
- FSM:
  - IDLE: eligible!=0 and !rti_ID_EX -> ASSERT. int_occurred=1 from the next cycle.
  - ASSERT: int_occurred=1. Re-arbitrate every cycle, so int_vec tracks the current winner.
    - stall_IM_ID=0 is the accept cycle -> ISR. On that edge: clear PENDING[winner], active_id<=winner, in_isr<=1, int_occurred<=0.
    - If eligible becomes 0 while stalled (masked, cleared or GIE dropped) -> IDLE; int_occurred drops the next cycle.
    - If rti_ID_EX arrives while in ASSERT, hold ASSERT with no accept that cycle; RTI has priority at the PC.
  - ISR: int_occurred=0; ignore eligible. rti_ID_EX=1 -> IDLE, in_isr<=0, active_id held.
  - The earliest re-entry is int_occurred high 2 cycles after the RTI cycle.
- int_occurred is a level held until accept. Exactly one accept per ISR entry.
- Asynchronous reset mid-ASSERT or mid-ISR returns everything to reset values immediately. Pending requests are lost.
- Latency: irq edge to int_occurred = 2 cycles when IDLE, enabled and unstalled.

Optional Feature:
- Macro IRQ_SYNC_EN defined: each irq line passes through a 2-flop synchronizer before edge detect. This adds 2 cycles (irq edge to int_occurred = 4 cycles).
- Macro not defined: irq is assumed synchronous to clk, with no synchronizer and 2-cycle latency.

Test Plan:
- MASK=8'hFF, GIE=1; pulse irq[3] -> int_occurred high 2 cycles later, int_vec=16'h0F0C; on accept PENDING[3]=0, in_isr=1, active_id=3.
- irq[5] then irq[1] edges 1 cycle apart while stall_IM_ID=1 -> int_vec moves 16'h0F14 -> 16'h0F04; accept services id 1; PENDING[5] stays 1.
- In ISR, pulse irq[0] -> no int_occurred; after rti_ID_EX, int_occurred high 2 cycles later with int_vec=16'h0F00.
- Pending irq[2], MASK=0 -> no request; write MASK=8'h04 -> int_occurred asserts; write PENDING=8'h04 while stalled -> int_occurred drops, FSM returns to IDLE.
- irq edge on bit 4 in the same cycle as a W1C write to bit 4 -> PENDING[4]=1.
- rst_n low while in ISR -> in_isr=0, int_occurred=0, MASK=0 and PENDING=0 immediately.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: priority interrupt controller sequencing ISR entry/exit for the PC.
// Define IRQ_SYNC_EN to put a 2-flop synchronizer on every irq line.
module int_ctrl #(
  parameter int          NUM_IRQ    = 8,
  parameter logic [15:0] VEC_BASE   = 16'h0F00,
  parameter int          VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               stall_IM_ID,
  input  logic               rti_ID_EX,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [15:0]        cfg_wdata,
  output logic [15:0]        cfg_rdata,
  output logic               int_occurred,
  output logic [15:0]        int_vec,
  output logic               in_isr,
  output logic [3:0]         active_id
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_ISR    = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic               gie_q, gie_d;
  logic               occ_q, occ_d;
  logic               isr_q, isr_d;
  logic [15:0]        vec_q, vec_d;
  logic [3:0]         act_q, act_d;

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] clr;
  logic [3:0]         win;
  logic [15:0]        vec_new;
  logic [15:0]        mask_ext;
  logic [15:0]        pend_ext;
  logic               unused_wdata;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq;
`endif

  assign irq_rise     = irq_s & ~prev_q;
  assign elig         = pend_q & mask_q & {NUM_IRQ{gie_q}};
  assign unused_wdata = ^cfg_wdata;

  // lowest index wins
  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) win = 4'(i);
    end
  end

  assign vec_new = VEC_BASE + 16'(win) * 16'(VEC_STRIDE);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    gie_d   = gie_q;
    vec_d   = vec_q;
    act_d   = act_q;
    clr     = '0;

    if (cfg_we) begin
      unique case (cfg_addr)
        2'd0:    mask_d = cfg_wdata[NUM_IRQ-1:0];
        2'd1:    clr    = cfg_wdata[NUM_IRQ-1:0];
        2'd2:    gie_d  = cfg_wdata[0];
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (|elig && !rti_ID_EX) begin
          state_d = ST_ASSERT;
          vec_d   = vec_new;
        end
      end
      ST_ASSERT: begin
        // RTI owns the PC this cycle, so no accept
        if (elig == '0) begin
          state_d = ST_IDLE;
        end else if (rti_ID_EX || stall_IM_ID) begin
          vec_d = vec_new;
        end else begin
          state_d = ST_ISR;
          clr     = clr | (NUM_IRQ'(1) << win);
          act_d   = win;
        end
      end
      ST_ISR: begin
        if (rti_ID_EX) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    occ_d  = (state_d == ST_ASSERT);
    isr_d  = (state_d == ST_ISR);
    pend_d = (pend_q & ~clr) | irq_rise;
    prev_d = irq_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      gie_q   <= 1'b0;
      occ_q   <= 1'b0;
      isr_q   <= 1'b0;
      vec_q   <= VEC_BASE;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
      gie_q   <= gie_d;
      occ_q   <= occ_d;
      isr_q   <= isr_d;
      vec_q   <= vec_d;
      act_q   <= act_d;
    end
  end

  always_comb begin
    mask_ext = '0;
    pend_ext = '0;
    mask_ext[NUM_IRQ-1:0] = mask_q;
    pend_ext[NUM_IRQ-1:0] = pend_q;
    unique case (cfg_addr)
      2'd0: cfg_rdata = mask_ext;
      2'd1: cfg_rdata = pend_ext;
      2'd2: cfg_rdata = {15'b0, gie_q};
      2'd3: cfg_rdata = {11'b0, isr_q, act_q};
    endcase
  end

  assign int_occurred = occ_q;
  assign int_vec      = vec_q;
  assign in_isr       = isr_q;
  assign active_id    = act_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed test-plan scenarios plus random traffic,
// checked every cycle against a behavioural model of the controller.
module tb_int_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] irq;
  logic         stall_IM_ID;
  logic         rti_ID_EX;
  logic         cfg_we;
  logic [1:0]   cfg_addr;
  logic [15:0]  cfg_wdata;
  logic [15:0]  cfg_rdata;
  logic         int_occurred;
  logic [15:0]  int_vec;
  logic         in_isr;
  logic [3:0]   active_id;

  int total = 0;
  int bad   = 0;

  int_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq          (irq),
    .stall_IM_ID  (stall_IM_ID),
    .rti_ID_EX    (rti_ID_EX),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .int_occurred (int_occurred),
    .int_vec      (int_vec),
    .in_isr       (in_isr),
    .active_id    (active_id)
  );

  always #5 clk = ~clk;

  // reference state: requesting / servicing flags instead of an FSM
  int unsigned m_mask, m_pend, m_prev, m_gie;
  bit          m_req, m_busy;
  int unsigned m_vec, m_act;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mask = 0; m_pend = 0; m_prev = 0; m_gie = 0;
    m_req = 0; m_busy = 0; m_vec = 'h0F00; m_act = 0;
  endtask

  function automatic int lowest(input int unsigned v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int unsigned full, ready, rise, clear;
    int w;
    full  = (1 << N) - 1;
    ready = m_gie != 0 ? (m_pend & m_mask) : 0;
    w     = lowest(ready);
    rise  = irq & ~m_prev & full;
    clear = 0;
    if (cfg_we && cfg_addr == 1) clear = cfg_wdata & full;
    if (m_busy) begin
      if (rti_ID_EX) m_busy = 0;
    end else if (m_req) begin
      if (ready == 0) m_req = 0;
      else if (rti_ID_EX || stall_IM_ID) m_vec = ('h0F00 + w * 4) & 'hFFFF;
      else begin
        clear |= (1 << w);
        m_act  = w;
        m_busy = 1;
        m_req  = 0;
      end
    end else if (ready != 0 && !rti_ID_EX) begin
      m_req = 1;
      m_vec = ('h0F00 + w * 4) & 'hFFFF;
    end
    m_pend = (m_pend & ~clear) | rise;
    if (cfg_we && cfg_addr == 0) m_mask = cfg_wdata & full;
    if (cfg_we && cfg_addr == 2) m_gie = cfg_wdata[0];
    m_prev = irq;
  endtask

  function automatic int unsigned model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_mask;
      2'd1:    return m_pend;
      2'd2:    return m_gie;
      default: return (int'(m_busy) << 4) | m_act;
    endcase
  endfunction

  task automatic check_outs(input string tag);
    check({tag, ".occ"}, int_occurred, m_req);
    check({tag, ".vec"}, int_vec, m_vec);
    check({tag, ".isr"}, in_isr, m_busy);
    check({tag, ".act"}, active_id, m_act);
    check({tag, ".rd"}, cfg_rdata, model_rd(cfg_addr));
  endtask

  task automatic tick();
    if (rst_n) model_step();
    else model_reset();
    @(posedge clk);
    #1;
    check_outs("cyc");
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a,
                          input logic [15:0] exp);
    cfg_addr = a;
    #1;
    check(tag, cfg_rdata, exp);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("arst");
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; stall_IM_ID = 1'b0; rti_ID_EX = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    model_reset();
    #12;
    check("rst_occ", int_occurred, 1'b0);
    check("rst_vec", int_vec, 16'h0F00);
    check("rst_isr", in_isr, 1'b0);
    check("rst_act", active_id, 4'd0);
    rd_check("rst_mask", 2'd0, 16'h0);
    rd_check("rst_ctrl", 2'd2, 16'h0);
    tick();
    rst_n = 1'b1;

    // single source, 2-cycle latency, accept
    wr(2'd0, 16'hFFFF);
    rd_check("mask_trunc", 2'd0, 16'h00FF);
    wr(2'd2, 16'h0001);
    irq = 8'h08; tick(); irq = '0;
    tick();
    check("s1_occ", int_occurred, 1'b1);
    check("s1_vec", int_vec, 16'h0F0C);
    tick();
    check("s1_isr", in_isr, 1'b1);
    check("s1_act", active_id, 4'd3);
    rd_check("s1_pend", 2'd1, 16'h0);
    rti_ID_EX = 1'b1; tick(); rti_ID_EX = 1'b0;

    // re-arbitration while stalled
    stall_IM_ID = 1'b1;
    irq = 8'h20; tick();
    irq = 8'h22; tick();
    check("s2_vec5", int_vec, 16'h0F14);
    tick();
    check("s2_vec1", int_vec, 16'h0F04);
    stall_IM_ID = 1'b0; tick();
    check("s2_act", active_id, 4'd1);
    rd_check("s2_pend", 2'd1, 16'h0020);
    irq = '0;

    // request during ISR waits for RTI
    irq = 8'h01; tick(); irq = '0;
    tick(); tick();
    check("s3_block", int_occurred, 1'b0);
    rti_ID_EX = 1'b1; tick(); rti_ID_EX = 1'b0;
    check("s3_rti1", int_occurred, 1'b0);
    tick();
    check("s3_occ", int_occurred, 1'b1);
    check("s3_vec", int_vec, 16'h0F00);
    tick();
    check("s3_act", active_id, 4'd0);
    rti_ID_EX = 1'b1; tick(); rti_ID_EX = 1'b0;
    tick(); tick();
    check("s3_act5", active_id, 4'd5);
    rti_ID_EX = 1'b1; tick(); rti_ID_EX = 1'b0;

    // masking and clear-while-stalled
    wr(2'd0, 16'h0000);
    irq = 8'h04; tick(); irq = '0;
    tick(); tick();
    check("s4_masked", int_occurred, 1'b0);
    stall_IM_ID = 1'b1;
    wr(2'd0, 16'h0004);
    tick();
    check("s4_occ", int_occurred, 1'b1);
    check("s4_vec", int_vec, 16'h0F08);
    wr(2'd1, 16'h0004);
    tick();
    check("s4_drop", int_occurred, 1'b0);
    wr(2'd0, 16'h00FF);
    stall_IM_ID = 1'b0;

    // set beats clear in the same cycle
    irq = 8'h10;
    wr(2'd1, 16'h0010);
    rd_check("s5_pend", 2'd1, 16'h0010);
    tick(); tick();
    irq = '0;
    check("s5_isr", in_isr, 1'b1);

    // async reset mid-ISR
    async_reset();
    rd_check("s6_mask", 2'd0, 16'h0);
    rd_check("s6_pend", 2'd1, 16'h0);

    // random traffic
    wr(2'd0, 16'h00FF);
    wr(2'd2, 16'h0001);
    for (int c = 0; c < 3000; c++) begin
      irq ^= N'($urandom & $urandom & $urandom);
      stall_IM_ID = ($urandom % 3) == 0;
      rti_ID_EX = m_busy ? (($urandom % 5) == 0) : (($urandom % 10) == 0);
      cfg_we = ($urandom % 10) == 0;
      cfg_addr = 2'($urandom);
      cfg_wdata = 16'($urandom);
      if (cfg_we && cfg_addr == 2'd0 && $urandom % 2 == 0) cfg_wdata = 16'hFFFF;
      if (cfg_we && cfg_addr == 2'd2 && $urandom % 4 != 0) cfg_wdata[0] = 1'b1;
      if (($urandom % 400) == 0) begin
        cfg_we = 1'b0;
        async_reset();
        wr(2'd0, 16'h00FF);
        wr(2'd2, 16'h0001);
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
